// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM states, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_op_sequencer_pkg;

   localparam int OPA_W = 64;
   localparam int OPB_W = 32;
   localparam int RES_W = 64;

   // Calculator op codes, same encoding as the button front end
   localparam logic [3:0] OP_ADD     = 4'h0;
   localparam logic [3:0] OP_SUB     = 4'h1;
   localparam logic [3:0] OP_MUL_INT = 4'h2;
   localparam logic [3:0] OP_DIV_INT = 4'h3;
   localparam logic [3:0] OP_AND     = 4'h4;
   localparam logic [3:0] OP_OR      = 4'h5;
   localparam logic [3:0] OP_MUL_FLT = 4'h6;
   localparam logic [3:0] OP_DIV_FLT = 4'h7;
   localparam logic [3:0] OP_XOR     = 4'h8;
   localparam logic [3:0] OP_NOT     = 4'h9;
   localparam logic [3:0] OP_CMP     = 4'hA;
   localparam logic [3:0] OP_EQ      = 4'hB;
   localparam logic [3:0] OP_LLS     = 4'hC;
   localparam logic [3:0] OP_LRS     = 4'hD;
   localparam logic [3:0] OP_ARS     = 4'hE;
   localparam logic [3:0] OP_CS      = 4'hF;

   // Bit i set: op code i runs on a multi-cycle unit with start/done handshake
   localparam logic [15:0] MULTI_MASK_DEF = 16'h00CC;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_COMMIT,
      S_ABORT
   } state_t;

   function automatic logic is_multi(input logic [15:0] mask, input logic [3:0] op);
      return mask[op];
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, unit-side and result signals between front end, ALU units and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: op_valid is only taken while op_ready is high; nothing is queued.
interface alu_op_sequencer_if;
   import alu_op_sequencer_pkg::*;

   // request side
   logic             op_valid;
   logic [3:0]       op_code;
   logic             op_ready;
   logic [OPA_W-1:0] num1_in;
   logic [OPB_W-1:0] num2_in;
   // unit side
   logic [OPA_W-1:0] opa_q;
   logic [OPB_W-1:0] opb_q;
   logic [31:0]      last_q;
   logic [3:0]       unit_sel;
   logic             unit_start;
   logic [RES_W-1:0] res_in;
   logic             done_in;
   logic             err_in;
   // result side
   logic [RES_W-1:0] result;
   logic [RES_W-1:0] lastresult;
   logic             busy;
   logic             err;

   // environment: front end plus ALU units and result mux
   modport master (
      output op_valid, op_code, num1_in, num2_in, res_in, done_in, err_in,
      input  op_ready, opa_q, opb_q, last_q, unit_sel, unit_start, result, lastresult, busy, err
   );

   // the sequencer itself
   modport slave (
      input  op_valid, op_code, num1_in, num2_in, res_in, done_in, err_in,
      output op_ready, opa_q, opb_q, last_q, unit_sel, unit_start, result, lastresult, busy, err
   );
endinterface

// File: rtl/alu_op_sequencer_timer.sv
// Loadable up/down counter with zero and terminal-count flags, shared by SETTLE and WAIT.
// Latency: load/count take effect on the next clock; flags are combinational from the count.
// Backpressure: none; counts only while enabled.
module alu_op_sequencer_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic         i_up,
   input  logic [W-1:0] i_term,
   output logic         o_zero,
   output logic         o_term
);
   logic [W-1:0] r_cnt;

   // load wins over counting; direction picked per cycle
   always_ff @(posedge i_clk) begin
      if (i_rst)       r_cnt <= '0;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_en)   r_cnt <= i_up ? r_cnt + 1'b1 : r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);
   assign o_term = (r_cnt == i_term);
endmodule

// File: rtl/alu_op_sequencer.sv
// Runs one calculator op at a time: freeze operands, start unit, wait settle/done, commit result.
// Latency: single-cycle ops COMB_WAIT+2 clk accept->result; multi-cycle ops commit the cycle after done.
// Backpressure: op_ready only in IDLE; requests while busy are dropped, not queued.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter logic [15:0] MULTI_MASK = MULTI_MASK_DEF,
   parameter int          COMB_WAIT  = 2,
   parameter int          TIMEOUT    = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   alu_op_sequencer_if.slave  io_alu
);
   localparam int          TW        = $clog2(TIMEOUT + COMB_WAIT + 1);
   localparam logic [TW-1:0] SETTLE_LD = TW'(COMB_WAIT - 1);
   // WAIT starts at count 0, so the last cycle that may see done holds TIMEOUT-1
   localparam logic [TW-1:0] WAIT_TERM = TW'(TIMEOUT - 1);

   state_t           r_state;
   logic [OPA_W-1:0] r_opa;
   logic [OPB_W-1:0] r_opb;
   logic [3:0]       r_op;
   logic             r_multi;
   logic             r_start;
   logic [RES_W-1:0] r_result;
   logic [RES_W-1:0] r_last;
   logic             r_err;
   logic             r_unit_err;
   logic             r_ready;

   logic             w_tmr_load;
   logic [TW-1:0]    w_tmr_load_val;
   logic             w_tmr_en;
   logic             w_tmr_up;
   logic             w_tmr_zero;
   logic             w_tmr_term;

   // timer control: load in ISSUE, count down in SETTLE, count up in WAIT
   always_comb begin
      w_tmr_load     = 1'b0;
      w_tmr_load_val = '0;
      w_tmr_en       = 1'b0;
      w_tmr_up       = 1'b0;
      case (r_state)
         S_ISSUE: begin
            w_tmr_load     = 1'b1;
            w_tmr_load_val = r_multi ? '0 : SETTLE_LD;
         end
         S_SETTLE: w_tmr_en = ~w_tmr_zero;
         S_WAIT: begin
            w_tmr_en = 1'b1;
            w_tmr_up = 1'b1;
         end
         default: ;
      endcase
   end

   alu_op_sequencer_timer #(.W(TW)) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_load_val),
      .i_en       (w_tmr_en),
      .i_up       (w_tmr_up),
      .i_term     (WAIT_TERM),
      .o_zero     (w_tmr_zero),
      .o_term     (w_tmr_term)
   );

   // sequencer FSM with all outputs registered
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_opa      <= '0;
         r_opb      <= '0;
         r_op       <= '0;
         r_multi    <= 1'b0;
         r_start    <= 1'b0;
         r_result   <= '0;
         r_last     <= '0;
         r_err      <= 1'b0;
         r_unit_err <= 1'b0;
         r_ready    <= 1'b1;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_alu.op_valid) begin
                  r_opa   <= io_alu.num1_in;
                  r_opb   <= io_alu.num2_in;
                  r_op    <= io_alu.op_code;
                  r_multi <= is_multi(MULTI_MASK, io_alu.op_code);
                  // start is visible during ISSUE so units begin while the timer loads
                  r_start <= is_multi(MULTI_MASK, io_alu.op_code);
                  r_err   <= 1'b0;
                  r_ready <= 1'b0;
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: r_state <= r_multi ? S_WAIT : S_SETTLE;
            S_SETTLE: begin
               if (w_tmr_zero) r_state <= S_COMMIT;
            end
            S_WAIT: begin
               // done on the terminal cycle still commits
               if (io_alu.done_in) begin
                  r_unit_err <= io_alu.err_in;
                  r_state    <= S_COMMIT;
               end else if (w_tmr_term) begin
                  r_err   <= 1'b1;
                  r_state <= S_ABORT;
               end
            end
            S_COMMIT: begin
               // a unit error still commits the unit's saturated value
               r_last   <= r_result;
               r_result <= io_alu.res_in;
               if (r_multi) r_err <= r_unit_err;
               r_ready  <= 1'b1;
               r_state  <= S_IDLE;
            end
            S_ABORT: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_alu.op_ready   = r_ready;
   assign io_alu.busy       = ~r_ready;
   assign io_alu.opa_q      = r_opa;
   assign io_alu.opb_q      = r_opb;
   // shift units chain off the most recently committed value, frozen between commits
   assign io_alu.last_q     = r_result[31:0];
   assign io_alu.unit_sel   = r_op;
   assign io_alu.unit_start = r_start;
   assign io_alu.result     = r_result;
   assign io_alu.lastresult = r_last;
   assign io_alu.err        = r_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: vector table, hand sequences and randomized ops vs. a reference model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
   import alu_op_sequencer_pkg::*;

   localparam int          COMB_WAIT  = 2;
   localparam int          TIMEOUT    = 255;
   localparam logic [15:0] MULTI_MASK = 16'h00CC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_op_sequencer_if bus();

   alu_op_sequencer #(
      .MULTI_MASK (MULTI_MASK),
      .COMB_WAIT  (COMB_WAIT),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_alu (bus)
   );

   // behavioural ALU units: what the external result mux returns for each op
   function automatic logic [63:0] unit_fn(input logic [3:0] op, input logic [63:0] a,
                                           input logic [31:0] b, input logic [31:0] l);
      logic [31:0] t;
      case (op)
         4'h0:    begin t = a[31:0] + b; unit_fn = {32'h0, t}; end
         4'h1:    begin t = a[31:0] - b; unit_fn = {32'h0, t}; end
         4'hC:    begin t = l << b[4:0]; unit_fn = {32'h0, t}; end
         default: unit_fn = a ^ {28'h0, op, b};
      endcase
   endfunction

   logic        force_en;
   logic [63:0] force_val;
   always_comb begin
      bus.res_in = unit_fn(bus.unit_sel, bus.opa_q, bus.opb_q, bus.last_q);
      if (force_en) bus.res_in = force_val;
   end

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Issue one op and follow it to completion; d = cycles from start pulse to done (<0 never)
   task automatic run_op(input logic [3:0] op, input logic [63:0] n1, input logic [31:0] n2,
                         input int d, input logic e,
                         output int busy, output int starts, output logic frozen,
                         output logic [31:0] last_seen);
      int c;
      int st_c;
      bus.op_valid = 1'b1;
      bus.op_code  = op;
      bus.num1_in  = n1;
      bus.num2_in  = n2;
      bus.err_in   = e;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      busy = 0; starts = 0; frozen = 1'b1; st_c = -1; c = 0; last_seen = '0;
      while (!bus.op_ready && c < 600) begin
         busy++;
         if (bus.unit_start) begin
            starts++;
            if (st_c < 0) st_c = c;
         end
         if (bus.opa_q !== n1 || bus.opb_q !== n2 || bus.unit_sel !== op) frozen = 1'b0;
         if (c == 0) last_seen = bus.last_q;
         bus.done_in  = (st_c >= 0 && d >= 0 && c == st_c + d);
         // operand edits and a request while busy must not disturb the op
         bus.num1_in  = {$urandom, $urandom};
         bus.num2_in  = $urandom;
         bus.op_valid = (c == 1);
         bus.op_code  = 4'($urandom);
         @(posedge clk); #1;
         c++;
      end
      bus.done_in  = 1'b0;
      bus.op_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [63:0] n1;
      logic [31:0] n2;
      int          d;
      logic        e;
      logic [63:0] exp_res;
      logic        exp_err;
      int          exp_busy;
      int          exp_starts;
      logic        commit;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0] m_res, m_last, exp;
      logic        m_err, frozen, e, multi;
      logic [31:0] lseen, n2;
      logic [63:0] n1;
      logic [3:0]  op;
      int          busy, starts, d, exp_busy, start_cnt;

      //            op    n1                      n2     d    e     result                  err  busy strt commit
      tbl[0] = '{4'h0, 64'd5,                  32'd7, 0,   1'b1, 64'd12,                 1'b0, 4,   0, 1'b1};
      tbl[1] = '{4'h1, 64'd10,                 32'd3, 0,   1'b0, 64'd7,                  1'b0, 4,   0, 1'b1};
      tbl[2] = '{4'h4, 64'h0F0,                32'h0F,0,   1'b0, 64'h0000_0004_0000_00FF,1'b0, 4,   0, 1'b1};
      tbl[3] = '{4'h3, 64'h0000_0001_0000_0002,32'd9, 20,  1'b0, 64'h0000_0002_0000_000B,1'b0, 22,  1, 1'b1};
      tbl[4] = '{4'h6, 64'd8,                  32'd8, 3,   1'b1, 64'h0000_0006_0000_0000,1'b1, 5,   1, 1'b1};
      tbl[5] = '{4'h2, 64'd3,                  32'd5, 1,   1'b0, 64'h0000_0002_0000_0006,1'b0, 3,   1, 1'b1};
      tbl[6] = '{4'h7, 64'h100,                32'd1, 255, 1'b0, 64'h0000_0007_0000_0101,1'b0, 257, 1, 1'b1};
      tbl[7] = '{4'h6, 64'd1,                  32'd1, -1,  1'b0, 64'h0,                  1'b1, 257, 1, 1'b0};
      tbl[8] = '{4'h3, 64'd2,                  32'd2, 256, 1'b0, 64'h0,                  1'b1, 257, 1, 1'b0};

      bus.op_valid = 1'b0; bus.op_code = '0; bus.num1_in = '0; bus.num2_in = '0;
      bus.done_in = 1'b0; bus.err_in = 1'b0;
      force_en = 1'b0; force_val = 64'hDEAD_BEEF_0BAD_F00D;

      // reset held three clocks
      rst = 1'b1;
      start_cnt = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.unit_start) start_cnt++;
      end
      chk("rst result", bus.result, 64'h0);
      chk("rst lastresult", bus.lastresult, 64'h0);
      chk("rst op_ready", 64'(bus.op_ready), 64'd1);
      chk("rst err", 64'(bus.err), 64'd0);
      chk("rst unit_sel", 64'(bus.unit_sel), 64'd0);
      chk("rst last_q", 64'(bus.last_q), 64'd0);
      chk("rst start pulses", 64'(start_cnt), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      m_res = '0; m_last = '0;

      // table vectors
      for (int i = 0; i < 9; i++) begin
         run_op(tbl[i].op, tbl[i].n1, tbl[i].n2, tbl[i].d, tbl[i].e, busy, starts, frozen, lseen);
         if (tbl[i].commit) begin
            m_last = m_res;
            m_res  = tbl[i].exp_res;
         end
         chk($sformatf("tbl%0d result", i), bus.result, m_res);
         chk($sformatf("tbl%0d lastresult", i), bus.lastresult, m_last);
         chk($sformatf("tbl%0d err", i), 64'(bus.err), 64'(tbl[i].exp_err));
         chk($sformatf("tbl%0d busy cycles", i), 64'(busy), 64'(tbl[i].exp_busy));
         chk($sformatf("tbl%0d start pulses", i), 64'(starts), 64'(tbl[i].exp_starts));
         chk($sformatf("tbl%0d frozen", i), 64'(frozen), 64'd1);
      end

      // stray done while idle must not commit
      force_en = 1'b1;
      bus.done_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.done_in = 1'b0;
      force_en = 1'b0;
      chk("stray done result", bus.result, m_res);
      chk("stray done lastresult", bus.lastresult, m_last);
      chk("stray done op_ready", 64'(bus.op_ready), 64'd1);

      // chain: add then shift reads the freshly committed value
      run_op(4'h0, 64'd5, 32'd7, 0, 1'b0, busy, starts, frozen, lseen);
      chk("chain add result", bus.result, 64'd12);
      run_op(4'hC, 64'h99, 32'd1, 0, 1'b0, busy, starts, frozen, lseen);
      chk("chain last_q during shift", 64'(lseen), 64'd12);
      chk("chain shift result", bus.result, 64'd24);
      chk("chain shift lastresult", bus.lastresult, 64'd12);
      chk("chain shift busy", 64'(busy), 64'(COMB_WAIT + 2));
      m_res = 64'd24; m_last = 64'd12;

      // randomized ops against the model
      for (int k = 0; k < 30; k++) begin
         op    = 4'($urandom);
         n1    = {$urandom, $urandom};
         n2    = $urandom;
         d     = $urandom_range(1, 40);
         e     = 1'($urandom);
         multi = MULTI_MASK[op];
         exp   = unit_fn(op, n1, n2, m_res[31:0]);
         run_op(op, n1, n2, d, e, busy, starts, frozen, lseen);
         m_last   = m_res;
         m_res    = exp;
         m_err    = multi ? e : 1'b0;
         exp_busy = multi ? d + 2 : COMB_WAIT + 2;
         chk($sformatf("rnd%0d op%0h result", k, op), bus.result, m_res);
         chk($sformatf("rnd%0d lastresult", k), bus.lastresult, m_last);
         chk($sformatf("rnd%0d err", k), 64'(bus.err), 64'(m_err));
         chk($sformatf("rnd%0d busy", k), 64'(busy), 64'(exp_busy));
         chk($sformatf("rnd%0d starts", k), 64'(starts), multi ? 64'd1 : 64'd0);
         chk($sformatf("rnd%0d frozen", k), 64'(frozen), 64'd1);
      end

      // reset in WAIT, then late done pulses: no commit, everything zeroed
      bus.op_valid = 1'b1; bus.op_code = 4'h3; bus.num1_in = 64'd7; bus.num2_in = 32'h55;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus.num2_in = 32'hFFFF_0000;
      @(posedge clk); #1;
      chk("midop opb_q stable", 64'(bus.opb_q), 64'h55);
      chk("midop busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      force_en = 1'b1;
      bus.done_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.done_in = 1'b0;
      force_en = 1'b0;
      chk("midrst op_ready", 64'(bus.op_ready), 64'd1);
      chk("midrst result", bus.result, 64'h0);
      chk("midrst lastresult", bus.lastresult, 64'h0);
      chk("midrst opb_q", 64'(bus.opb_q), 64'h0);
      chk("midrst opa_q", bus.opa_q, 64'h0);
      chk("midrst unit_sel", 64'(bus.unit_sel), 64'h0);
      chk("midrst err", 64'(bus.err), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
